// File: rtl/aste_mover.sv
// aste_mover: fetches asteroid spawn words from the spawn-table ROM in
// round-robin order and steps the asteroid across the grid on each tick.
module aste_mover #(
  parameter int NUM_ENTRIES = 4,
  parameter int GRID_MAX    = 14
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spawn,
  input  logic       tick,
  input  logic       destroy,
  input  logic [9:0] rom_q,
  output logic [3:0] rom_addr,
  output logic [3:0] aste_x,
  output logic [3:0] aste_y,
  output logic [1:0] aste_dir,
  output logic       active,
  output logic       done
);

  localparam logic [3:0] GRID_HI  = 4'(GRID_MAX);
  localparam logic [3:0] LAST_IDX = 4'(NUM_ENTRIES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    MOVE  = 2'd3
  } state_t;

  state_t     state, state_next;
  logic [3:0] idx, idx_next;
  logic [3:0] x_next, y_next;
  logic [1:0] dir_next;
  logic       done_next;
  logic       at_edge;
  logic [3:0] idx_adv;

  // The ROM registers the address itself, so the index drives it directly.
  assign rom_addr = idx;
  assign active   = (state == MOVE);
  assign idx_adv  = (idx == LAST_IDX) ? 4'd0 : idx + 4'd1;

  // Flag when the coordinate that moves in the current direction sits on its edge.
  always_comb begin
    at_edge = 1'b0;
    case (aste_dir)
      2'b00:   at_edge = (aste_x == GRID_HI);
      2'b01:   at_edge = (aste_x == 4'd0);
      2'b10:   at_edge = (aste_y == GRID_HI);
      default: at_edge = (aste_y == 4'd0);
    endcase
  end

  // Next-state, coordinate and done logic; everything holds unless a case changes it.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    x_next     = aste_x;
    y_next     = aste_y;
    dir_next   = aste_dir;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (spawn) state_next = FETCH;
      end
      FETCH: begin
        state_next = LOAD;
      end
      LOAD: begin
        x_next     = rom_q[9:6];
        y_next     = rom_q[5:2];
        dir_next   = rom_q[1:0];
        state_next = MOVE;
      end
      MOVE: begin
        if (destroy) begin
          state_next = IDLE;
          idx_next   = idx_adv;
        end else if (tick && at_edge) begin
          state_next = IDLE;
          idx_next   = idx_adv;
          done_next  = 1'b1;
        end else if (tick) begin
          case (aste_dir)
            2'b00:   x_next = aste_x + 4'd1;
            2'b01:   x_next = aste_x - 4'd1;
            2'b10:   y_next = aste_y + 4'd1;
            default: y_next = aste_y - 4'd1;
          endcase
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, index, coordinates and the done pulse all update on the clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= 4'd0;
      aste_x   <= 4'd0;
      aste_y   <= 4'd0;
      aste_dir <= 2'b00;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      aste_x   <= x_next;
      aste_y   <= y_next;
      aste_dir <= dir_next;
      done     <= done_next;
    end
  end

endmodule

// File: tb/tb_aste_mover.sv
// Testbench for aste_mover: a spec-level cycle model pushes expected outputs
// into a queue as each stimulus cycle is driven; they are popped and compared
// one time unit after the clock edge. Directed checks cover the test plan.
module tb_aste_mover;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       spawn = 1'b0;
  logic       tick = 1'b0;
  logic       destroy = 1'b0;
  logic [9:0] rom_q = 10'd0;
  logic [3:0] rom_addr;
  logic [3:0] aste_x;
  logic [3:0] aste_y;
  logic [1:0] aste_dir;
  logic       active;
  logic       done;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] addr;
    logic [3:0] x;
    logic [3:0] y;
    logic [1:0] dir;
    logic       act;
    logic       dn;
  } exp_t;

  exp_t expQ[$];

  logic [9:0] rom [4];

  int         mState;
  logic [3:0] mIdx, mX, mY;
  logic [1:0] mDir;
  logic       mDone;

  aste_mover #(.NUM_ENTRIES(4), .GRID_MAX(14)) dut (
    .clk(clk), .reset(reset), .spawn(spawn), .tick(tick), .destroy(destroy),
    .rom_q(rom_q), .rom_addr(rom_addr), .aste_x(aste_x), .aste_y(aste_y),
    .aste_dir(aste_dir), .active(active), .done(done)
  );

  always #5 clk = ~clk;

  // Spawn-table ROM with a registered address.
  always @(posedge clk) rom_q <= rom[rom_addr[1:0]];

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mState = 0; mIdx = 4'd0; mX = 4'd0; mY = 4'd0; mDir = 2'b00; mDone = 1'b0;
  endtask

  // Advance the spec model by one clock using the inputs being driven now.
  task automatic modelStep(input logic s, input logic t, input logic d);
    logic edgeHit;
    mDone = 1'b0;
    case (mState)
      0: if (s) mState = 1;
      1: mState = 2;
      2: begin
        mX = rom[mIdx[1:0]][9:6];
        mY = rom[mIdx[1:0]][5:2];
        mDir = rom[mIdx[1:0]][1:0];
        mState = 3;
      end
      default: begin
        edgeHit = (mDir == 2'b00 && mX == 4'd14) || (mDir == 2'b01 && mX == 4'd0) ||
                  (mDir == 2'b10 && mY == 4'd14) || (mDir == 2'b11 && mY == 4'd0);
        if (d) begin
          mState = 0; mIdx = (mIdx == 4'd3) ? 4'd0 : mIdx + 4'd1;
        end else if (t && edgeHit) begin
          mState = 0; mDone = 1'b1; mIdx = (mIdx == 4'd3) ? 4'd0 : mIdx + 4'd1;
        end else if (t) begin
          case (mDir)
            2'b00: mX = mX + 4'd1;
            2'b01: mX = mX - 4'd1;
            2'b10: mY = mY + 4'd1;
            default: mY = mY - 4'd1;
          endcase
        end
      end
    endcase
  endtask

  task automatic applyStimulus(input logic s, input logic t, input logic d);
    exp_t e;
    exp_t got;
    @(negedge clk);
    spawn = s; tick = t; destroy = d;
    modelStep(s, t, d);
    e.addr = mIdx; e.x = mX; e.y = mY; e.dir = mDir; e.act = (mState == 3); e.dn = mDone;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    if (expQ.size() == 0) begin
      checkOutput("queue_empty", 8'd0, 8'd1);
    end else begin
      got = expQ.pop_front();
      checkOutput("rom_addr", {4'd0, rom_addr}, {4'd0, got.addr});
      checkOutput("aste_x", {4'd0, aste_x}, {4'd0, got.x});
      checkOutput("aste_y", {4'd0, aste_y}, {4'd0, got.y});
      checkOutput("aste_dir", {6'd0, aste_dir}, {6'd0, got.dir});
      checkOutput("active", {7'd0, active}, {7'd0, got.act});
      checkOutput("done", {7'd0, done}, {7'd0, got.dn});
    end
  endtask

  // Spawn, then wait out FETCH and LOAD; optional spawn/tick noise during them.
  task automatic spawnAndLoad(input logic noise);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(noise, noise, 1'b0);
    applyStimulus(1'b0, noise, 1'b0);
  endtask

  // Tick with random gaps until the asteroid exits, within a cycle budget.
  task automatic runToExit(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      if (done) seen = 1'b1;
    end
    checkOutput(tag, {7'd0, seen}, 8'd1);
  endtask

  initial begin
    rom[0] = 10'b0000_0111_00;
    rom[1] = 10'b1110_0111_01;
    rom[2] = 10'b0111_0000_10;
    rom[3] = 10'b0111_1110_11;
    modelReset();

    #12;
    checkOutput("rst_addr", {4'd0, rom_addr}, 8'd0);
    checkOutput("rst_active", {7'd0, active}, 8'd0);
    reset = 1'b0;

    // Entry 0: moves right from x=0 to the edge.
    spawnAndLoad(1'b0);
    checkOutput("t1_active", {7'd0, active}, 8'd1);
    checkOutput("t1_y", {4'd0, aste_y}, 8'd7);
    for (int i = 0; i < 14; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t1_x14", {4'd0, aste_x}, 8'd14);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t1_done", {7'd0, done}, 8'd1);
    checkOutput("t1_addr1", {4'd0, rom_addr}, 8'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t1_done_low", {7'd0, done}, 8'd0);

    // Entry 1: moves left to 0 with spawn/tick noise during FETCH and LOAD.
    spawnAndLoad(1'b1);
    checkOutput("t2_x14", {4'd0, aste_x}, 8'd14);
    for (int i = 0; i < 14; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("t2_x0", {4'd0, aste_x}, 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t2_done", {7'd0, done}, 8'd1);
    checkOutput("t2_nowrap", {4'd0, aste_x}, 8'd0);

    // Entry 2: vertical, then tick and destroy together at y=5.
    spawnAndLoad(1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("t3_inactive", {7'd0, active}, 8'd0);
    checkOutput("t3_nodone", {7'd0, done}, 8'd0);
    checkOutput("t3_y5", {4'd0, aste_y}, 8'd5);
    checkOutput("t3_addr3", {4'd0, rom_addr}, 8'd3);
    applyStimulus(1'b0, 1'b1, 1'b1);

    // Entry 3: moves down from y=14, x must stay 7.
    spawnAndLoad(1'b0);
    runToExit("t4_exit");
    checkOutput("t4_x7", {4'd0, aste_x}, 8'd7);
    checkOutput("t4_y0", {4'd0, aste_y}, 8'd0);
    checkOutput("t4_addr0", {4'd0, rom_addr}, 8'd0);

    // Two more full rounds with random tick gaps.
    for (int r = 0; r < 2; r++) begin
      spawnAndLoad(1'b0);
      runToExit("loop_exit");
    end

    // Asynchronous reset in the middle of MOVE.
    spawnAndLoad(1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    spawn = 1'b0; tick = 1'b0; destroy = 1'b0;
    #2 reset = 1'b1;
    #1;
    checkOutput("ar_x", {4'd0, aste_x}, 8'd0);
    checkOutput("ar_y", {4'd0, aste_y}, 8'd0);
    checkOutput("ar_dir", {6'd0, aste_dir}, 8'd0);
    checkOutput("ar_active", {7'd0, active}, 8'd0);
    checkOutput("ar_done", {7'd0, done}, 8'd0);
    checkOutput("ar_addr", {4'd0, rom_addr}, 8'd0);
    #1 reset = 1'b0;
    modelReset();
    applyStimulus(1'b0, 1'b1, 1'b0);
    spawnAndLoad(1'b0);
    checkOutput("ar_entry0_y", {4'd0, aste_y}, 8'd7);
    runToExit("ar_exit");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
